pattern_detector_moore: RTL and testbench

Parametrised serial pattern detector, Moore style. It matches a programmable PAT_W-bit pattern on a 1-bit input stream qualified by a sample enable. It supports overlapping and non-overlapping match modes and keeps a saturating match counter. It sits on serial control/data lines as a generalised drop-in for fixed two-bit sequence recognisers: PAT_W=2 with pattern 2'b01 gives the classic "0 then 1" detector.

---
 rtl/pattern_detector_moore_pkg.sv | 12 +
 rtl/pattern_detector_moore_sat_counter.sv | 28 ++
 rtl/pattern_detector_moore.sv | 78 +++++++
 tb/tb_pattern_detector_moore.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_detector_moore_pkg.sv
// Shared types and constants for the serial pattern detector.
// The match mode enum gives the overlap input a name at its point of use.
package pattern_det_pkg;

   localparam int DEFAULT_PAT_W = 4;

   typedef enum logic {
      MODE_NONOVERLAP = 1'b0,
      MODE_OVERLAP    = 1'b1
   } match_mode_t;

endpackage

// File: rtl/pattern_detector_moore_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the match count.
// It sticks at all-ones and never wraps; sat flags that condition.
module sat_counter
   import pattern_det_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q,
   output logic         sat
);

   assign sat = &q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && !sat) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/pattern_detector_moore.sv
// Moore serial pattern detector: the state is (fill, shreg), and y is a pure
// register output, so it never reacts combinationally to the serial input.
module pattern_detector_moore
   import pattern_det_pkg::*;
#(
   parameter int               PAT_W   = DEFAULT_PAT_W,
   parameter int               CNT_W   = 8,
   parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1011)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             a,
   input  logic             load,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   output logic             y,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat
);

   localparam int             FW   = $clog2(PAT_W + 1);
   localparam logic [FW-1:0]  FULL = FW'(PAT_W);

   // en is a plain sample strobe: a is consumed on every cycle with en=1 and
   // load=0; there is no back-pressure. load wins and drops that cycle's sample.
   typedef struct packed {
      logic [FW-1:0]    fill;
      logic [PAT_W-1:0] shreg;
   } det_state_t;

   det_state_t       state_q;
   logic [PAT_W-1:0] pat_q;
   logic [PAT_W-1:0] sh_n;
   logic [FW-1:0]    fill_n;
   logic             hit;
   logic             inc;
   match_mode_t      mode;

   assign mode = match_mode_t'(overlap);

   if (PAT_W == 1) begin : g_sh_one
      assign sh_n = a;
   end else begin : g_sh_many
      assign sh_n = {state_q.shreg[PAT_W-2:0], a};
   end

   assign fill_n = (state_q.fill == FULL) ? FULL : state_q.fill + 1'b1;
   assign hit    = (fill_n == FULL) && (sh_n == pat_q);
   assign inc    = en && !load && hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q   <= RST_PAT;
         state_q <= '0;
         y       <= 1'b0;
      end else if (load) begin
         pat_q   <= pattern;
         state_q <= '0;
         y       <= 1'b0;
      end else if (en) begin
         state_q.shreg <= sh_n;
         // Non-overlap mode restarts the fill so the next match needs PAT_W fresh bits.
         state_q.fill  <= (hit && mode == MODE_NONOVERLAP) ? '0 : fill_n;
         y             <= hit;
      end
   end

   sat_counter #(.W(CNT_W)) u_count (
      .clk   (clk),
      .reset (reset),
      .clr   (load),
      .inc   (inc),
      .q     (match_count),
      .sat   (count_sat)
   );

endmodule

// File: tb/tb_pattern_detector_moore.sv
// Directed bench for pattern_detector_moore: default build, a narrow-counter
// build for saturation, and a two-bit "0 then 1" legacy build.
module tb_pattern_detector_moore;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       a;
   logic       load;
   logic       overlap;
   logic [3:0] pattern;
   logic [1:0] pattern2;

   logic       y0, y1, y2;
   logic [7:0] cnt0;
   logic [2:0] cnt1;
   logic [7:0] cnt2;
   logic       sat0, sat1, sat2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pattern_detector_moore u0 (
      .clk(clk), .reset(reset), .en(en), .a(a), .load(load), .pattern(pattern),
      .overlap(overlap), .y(y0), .match_count(cnt0), .count_sat(sat0)
   );

   pattern_detector_moore #(.PAT_W(4), .CNT_W(3)) u1 (
      .clk(clk), .reset(reset), .en(en), .a(a), .load(load), .pattern(pattern),
      .overlap(overlap), .y(y1), .match_count(cnt1), .count_sat(sat1)
   );

   pattern_detector_moore #(.PAT_W(2), .CNT_W(8), .RST_PAT(2'b01)) u2 (
      .clk(clk), .reset(reset), .en(en), .a(a), .load(load), .pattern(pattern2),
      .overlap(overlap), .y(y2), .match_count(cnt2), .count_sat(sat2)
   );

   // Presents one bit with en=1 and returns 1 time unit after the sampling edge.
   task automatic sample(input logic b);
      en = 1'b1;
      a  = b;
      @(posedge clk);
      #1;
      en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #3;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] bits;
      logic [3:0] expy;
      // Power-on values while reset is still held.
      checks++; if (y0 !== 1'b0) begin errors++; $display("FAIL por_y got %b want 0", y0); end
      checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL por_count got %0d want 0", cnt0); end
      checks++; if (sat0 !== 1'b0) begin errors++; $display("FAIL por_sat got %b want 0", sat0); end
      reset = 1'b0;
      idle(1);
      overlap = 1'b1;
      sample(1'b1); sample(1'b0); sample(1'b1); sample(1'b1);
      checks++; if (y0 !== 1'b1 || cnt0 !== 8'd1) begin errors++; $display("FAIL pre_reset_match y=%b cnt=%0d want 1/1", y0, cnt0); end
      // Mid-cycle asynchronous reset: outputs must clear without a clock edge.
      reset = 1'b1;
      #1;
      checks++; if (y0 !== 1'b0) begin errors++; $display("FAIL async_reset_y got %b want 0", y0); end
      checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL async_reset_count got %0d want 0", cnt0); end
      checks++; if (sat0 !== 1'b0) begin errors++; $display("FAIL async_reset_sat got %b want 0", sat0); end
      #2;
      reset = 1'b0;
      bits = 4'b1011;
      expy = 4'b0001;
      for (int i = 3; i >= 0; i--) begin
         sample(bits[i]);
         checks++;
         if (y0 !== expy[i]) begin errors++; $display("FAIL reset_pattern_s%0d got %b want %b", 4 - i, y0, expy[i]); end
      end
   endtask

   task automatic test_overlap();
      logic [6:0] bits;
      logic [6:0] expy;
      pulse_reset();
      overlap = 1'b1;
      bits = 7'b1011011;
      expy = 7'b0001001;
      for (int i = 6; i >= 0; i--) begin
         sample(bits[i]);
         checks++;
         if (y0 !== expy[i]) begin errors++; $display("FAIL overlap_s%0d got %b want %b", 7 - i, y0, expy[i]); end
      end
      checks++; if (cnt0 !== 8'd2) begin errors++; $display("FAIL overlap_count got %0d want 2", cnt0); end
   endtask

   task automatic test_nonoverlap();
      logic [6:0] bits;
      logic [6:0] expy;
      pulse_reset();
      overlap = 1'b0;
      bits = 7'b1011011;
      expy = 7'b0001000;
      for (int i = 6; i >= 0; i--) begin
         sample(bits[i]);
         checks++;
         if (y0 !== expy[i]) begin errors++; $display("FAIL nonoverlap_s%0d got %b want %b", 7 - i, y0, expy[i]); end
      end
      checks++; if (cnt0 !== 8'd1) begin errors++; $display("FAIL nonoverlap_count got %0d want 1", cnt0); end
   endtask

   task automatic test_gaps_and_load();
      logic [3:0] bits;
      logic [3:0] expy;
      pulse_reset();
      overlap = 1'b1;
      sample(1'b1); sample(1'b0);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         checks++; if (y0 !== 1'b0) begin errors++; $display("FAIL gap_low_c%0d got %b want 0", i, y0); end
      end
      sample(1'b1); sample(1'b1);
      checks++; if (y0 !== 1'b1) begin errors++; $display("FAIL gap_match got %b want 1", y0); end
      for (int i = 0; i < 2; i++) begin
         idle(1);
         checks++; if (y0 !== 1'b1) begin errors++; $display("FAIL gap_hold_c%0d got %b want 1", i, y0); end
      end
      // 1011 then 0,1,1 re-forms 1011 in overlap mode: second match.
      sample(1'b0); sample(1'b1); sample(1'b1);
      checks++; if (y0 !== 1'b1 || cnt0 !== 8'd2) begin errors++; $display("FAIL pre_load y=%b cnt=%0d want 1/2", y0, cnt0); end
      // Load cycle also carries an en sample of 0, which must be discarded.
      load = 1'b1; pattern = 4'b0110;
      sample(1'b0);
      load = 1'b0;
      checks++; if (y0 !== 1'b0 || cnt0 !== 8'd0) begin errors++; $display("FAIL load_clear y=%b cnt=%0d want 0/0", y0, cnt0); end
      sample(1'b0);
      checks++; if (y0 !== 1'b0) begin errors++; $display("FAIL post_load_first got %b want 0", y0); end
      bits = 4'b0110;
      expy = 4'b0001;
      for (int i = 3; i >= 0; i--) begin
         sample(bits[i]);
         checks++;
         if (y0 !== expy[i]) begin errors++; $display("FAIL new_pattern_s%0d got %b want %b", 4 - i, y0, expy[i]); end
      end
      checks++; if (cnt0 !== 8'd1) begin errors++; $display("FAIL new_pattern_count got %0d want 1", cnt0); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] expy;
      pulse_reset();
      load = 1'b1; pattern = 4'b1111;
      idle(1);
      load = 1'b0;
      overlap = 1'b1;
      expy = 8'b00011111;
      for (int i = 7; i >= 0; i--) begin
         sample(1'b1);
         checks++;
         if (y0 !== expy[i]) begin errors++; $display("FAIL b2b_overlap_s%0d got %b want %b", 8 - i, y0, expy[i]); end
      end
      checks++; if (cnt0 !== 8'd5) begin errors++; $display("FAIL b2b_overlap_count got %0d want 5", cnt0); end
      // Switching to non-overlap: fill is already full, so the next 1 still hits and restarts.
      overlap = 1'b0;
      expy = 8'b10001000;
      for (int i = 7; i >= 0; i--) begin
         sample(1'b1);
         checks++;
         if (y0 !== expy[i]) begin errors++; $display("FAIL b2b_nonoverlap_s%0d got %b want %b", 8 - i, y0, expy[i]); end
      end
      checks++; if (cnt0 !== 8'd7) begin errors++; $display("FAIL b2b_nonoverlap_count got %0d want 7", cnt0); end
   endtask

   task automatic test_saturation();
      logic [3:0] bits;
      int         exp_cnt;
      pulse_reset();
      overlap = 1'b0;
      bits = 4'b1011;
      for (int k = 1; k <= 9; k++) begin
         for (int i = 3; i >= 0; i--) sample(bits[i]);
         exp_cnt = (k > 7) ? 7 : k;
         checks++;
         if (cnt1 !== 3'(exp_cnt)) begin errors++; $display("FAIL sat_count_m%0d got %0d want %0d", k, cnt1, exp_cnt); end
         checks++;
         if (sat1 !== (k >= 7)) begin errors++; $display("FAIL sat_flag_m%0d got %b want %b", k, sat1, (k >= 7)); end
      end
      checks++; if (cnt0 !== 8'd9 || sat0 !== 1'b0) begin errors++; $display("FAIL wide_count got %0d/%b want 9/0", cnt0, sat0); end
   endtask

   task automatic test_legacy();
      logic [4:0] bits;
      logic [4:0] expy;
      pulse_reset();
      overlap = 1'b1;
      bits = 5'b01101;
      expy = 5'b01001;
      for (int i = 4; i >= 0; i--) begin
         sample(bits[i]);
         checks++;
         if (y2 !== expy[i]) begin errors++; $display("FAIL legacy_s%0d got %b want %b", 5 - i, y2, expy[i]); end
      end
      checks++; if (cnt2 !== 8'd2) begin errors++; $display("FAIL legacy_count got %0d want 2", cnt2); end
   endtask

   initial begin
      reset    = 1'b1;
      en       = 1'b0;
      a        = 1'b0;
      load     = 1'b0;
      overlap  = 1'b1;
      pattern  = 4'b0000;
      pattern2 = 2'b01;
      #12;
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_gaps_and_load();
      test_back_to_back();
      test_saturation();
      test_legacy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
